// File: rtl/bch_decode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bch_decode_sequencer
// Brief    : Sequential (15,5) BCH decoder: syndrome, then single/double flip search
// Revision : 1.0
// ============================================================================
module bch_decode_sequencer #(
    parameter int          MAX_ERR = 2,
    parameter logic [10:0] GEN     = 11'b10100110111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] codeword_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  data_out,
    output logic [14:0] corrected_codeword,
    output logic [9:0]  syndrome,
    output logic        error_detected,
    output logic        error_corrected,
    output logic [6:0]  trial_count,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYND  = 3'd1,
        S_SCAN1 = 3'd2,
        S_SCAN2 = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    logic [14:0] r_word;
    logic [14:0] r_corr;
    logic [9:0]  r_synd;
    logic        r_err_det;
    logic        r_err_cor;
    logic [6:0]  r_trials;
    logic [3:0]  r_i;
    logic [3:0]  r_j;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_busy;

    logic [14:0] w_mask;
    logic [14:0] w_trial;
    logic [9:0]  w_rem;

    // Long division by GEN, clearing bits 14..10 from the top down.
    function automatic logic [9:0] f_syndrome(input logic [14:0] word);
        logic [14:0] rem;
        rem = word;
        for (int b = 14; b >= 10; b--) begin
            if (rem[b]) begin
                rem = rem ^ (15'(GEN) << (b - 10));
            end
        end
        return rem[9:0];
    endfunction

    // One shared remainder unit: the mask selects which trial is evaluated.
    always_comb begin
        w_mask = 15'd0;
        case (r_state)
            S_SCAN1: w_mask = 15'd1 << r_i;
            S_SCAN2: w_mask = (15'd1 << r_i) | (15'd1 << r_j);
            default: w_mask = 15'd0;
        endcase
    end

    assign w_trial = r_word ^ w_mask;
    assign w_rem   = f_syndrome(w_trial);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_word      <= 15'd0;
            r_corr      <= 15'd0;
            r_synd      <= 10'd0;
            r_err_det   <= 1'b0;
            r_err_cor   <= 1'b0;
            r_trials    <= 7'd0;
            r_i         <= 4'd0;
            r_j         <= 4'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_word     <= codeword_in;
                        r_corr     <= codeword_in;
                        r_synd     <= 10'd0;
                        r_err_det  <= 1'b0;
                        r_err_cor  <= 1'b0;
                        r_trials   <= 7'd0;
                        r_state    <= S_SYND;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_SYND: begin
                    r_synd <= w_rem;
                    if (w_rem == 10'd0) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_err_det <= 1'b1;
                        r_i       <= 4'd0;
                        r_state   <= S_SCAN1;
                    end
                end
                S_SCAN1: begin
                    r_trials <= r_trials + 7'd1;
                    if (w_rem == 10'd0) begin
                        r_corr      <= w_trial;
                        r_err_cor   <= 1'b1;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else if (r_i == 4'd14) begin
                        if (MAX_ERR >= 2) begin
                            r_i     <= 4'd0;
                            r_j     <= 4'd1;
                            r_state <= S_SCAN2;
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end
                    end else begin
                        r_i <= r_i + 4'd1;
                    end
                end
                S_SCAN2: begin
                    r_trials <= r_trials + 7'd1;
                    if (w_rem == 10'd0) begin
                        r_corr      <= w_trial;
                        r_err_cor   <= 1'b1;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else if (r_i == 4'd13 && r_j == 4'd14) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else if (r_j == 4'd14) begin
                        r_i <= r_i + 4'd1;
                        r_j <= r_i + 4'd2;
                    end else begin
                        r_j <= r_j + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready           = r_in_ready;
    assign out_valid          = r_out_valid;
    assign busy               = r_busy;
    assign corrected_codeword = r_corr;
    assign data_out           = r_corr[14:10];
    assign syndrome           = r_synd;
    assign error_detected     = r_err_det;
    assign error_corrected    = r_err_cor;
    assign trial_count        = r_trials;

endmodule
`default_nettype wire

// File: tb/tb_bch_decode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bch_decode_sequencer
// Brief    : Self-checking bench with a cycle-level reference model of the decoder
// Revision : 1.0
// ============================================================================
module tb_bch_decode_sequencer;

    localparam logic [10:0] C_GEN = 11'b10100110111;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] codeword_in;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  data_out;
    logic [14:0] corrected_codeword;
    logic [9:0]  syndrome;
    logic        error_detected;
    logic        error_corrected;
    logic [6:0]  trial_count;
    logic        busy;

    bch_decode_sequencer #(.MAX_ERR(2), .GEN(C_GEN)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush              (flush),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .codeword_in        (codeword_in),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .data_out           (data_out),
        .corrected_codeword (corrected_codeword),
        .syndrome           (syndrome),
        .error_detected     (error_detected),
        .error_corrected    (error_corrected),
        .trial_count        (trial_count),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] corr;
        logic [9:0]  syn;
        logic        det;
        logic        cor;
        int          k;
    } exp_t;

    int checks   = 0;
    int failures = 0;
    int tmo_count = 0;
    int tmo_seen  = 0;

    // Syndrome by linearity: XOR of x^b mod g over the set bits of the word.
    function automatic logic [9:0] ref_synd(input logic [14:0] w);
        logic [9:0] p;
        logic [9:0] s;
        p = 10'h001;
        s = 10'h000;
        for (int b = 0; b < 15; b++) begin
            if (w[b]) s = s ^ p;
            p = {p[8:0], 1'b0} ^ (p[9] ? C_GEN[9:0] : 10'h000);
        end
        return s;
    endfunction

    function automatic exp_t ref_job(input logic [14:0] w);
        exp_t e;
        logic [14:0] t;
        logic        found;
        e.corr = w;
        e.syn  = ref_synd(w);
        e.det  = (e.syn != 10'd0);
        e.cor  = 1'b0;
        e.k    = 0;
        found  = !e.det;
        for (int i = 0; i < 15 && !found; i++) begin
            e.k++;
            t = w ^ (15'd1 << i);
            if (ref_synd(t) == 10'd0) begin
                found = 1'b1; e.cor = 1'b1; e.corr = t;
            end
        end
        for (int i = 0; i < 14 && !found; i++) begin
            for (int j = i + 1; j < 15 && !found; j++) begin
                e.k++;
                t = w ^ (15'd1 << i) ^ (15'd1 << j);
                if (ref_synd(t) == 10'd0) begin
                    found = 1'b1; e.cor = 1'b1; e.corr = t;
                end
            end
        end
        return e;
    endfunction

    function automatic logic [14:0] gen_word();
        logic [4:0]  d;
        logic [14:0] cw;
        int          n;
        d  = 5'($urandom_range(0, 31));
        cw = 15'd0;
        for (int b = 0; b < 5; b++) begin
            if (d[b]) cw = cw ^ (15'(C_GEN) << b);
        end
        n = $urandom_range(0, 3);
        for (int f = 0; f < n; f++) begin
            cw = cw ^ (15'd1 << $urandom_range(0, 14));
        end
        return cw;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Compare process: model state 0=idle, 1=working, 2=result presented.
    int   m_st;
    int   m_rem;
    exp_t m_job;

    initial begin
        exp_t e;
        m_st  = 0;
        m_rem = 0;
        e = ref_job(15'h0537);
        chk("pin_0537_k",   32'(e.k), 32'd0);
        chk("pin_0537_det", 32'(e.det), 32'd0);
        e = ref_job(15'h0536);
        chk("pin_0536_k",   32'(e.k), 32'd1);
        chk("pin_0536_syn", 32'(e.syn), 32'h001);
        chk("pin_0536_cw",  32'(e.corr), 32'h0537);
        e = ref_job(15'h4537);
        chk("pin_4537_k",   32'(e.k), 32'd15);
        chk("pin_4537_cw",  32'(e.corr), 32'h0537);
        e = ref_job(15'h0534);
        chk("pin_0534_k",   32'(e.k), 32'd16);
        chk("pin_0534_cw",  32'(e.corr), 32'h0537);
        e = ref_job(15'h0530);
        chk("pin_0530_k",   32'(e.k), 32'd120);
        chk("pin_0530_cor", 32'({e.det, e.cor}), 32'b10);
        chk("pin_0530_cw",  32'(e.corr), 32'h0530);
        forever begin
            @(negedge clk);
            if (tmo_count != tmo_seen) begin
                checks++;
                failures++;
                tmo_seen++;
            end
            if (!rst_n) begin
                chk("reset_hs", 32'({in_ready, out_valid, busy}), 32'b100);
                chk("reset_outs", 32'({data_out, corrected_codeword, syndrome,
                    error_detected, error_corrected, trial_count}), 32'd0);
                m_st = 0;
            end else begin
                chk("handshake", 32'({in_ready, out_valid, busy}),
                    32'({m_st == 0, m_st == 2, m_st != 0}));
                if (m_st == 2) begin
                    chk("corrected", 32'(corrected_codeword), 32'(m_job.corr));
                    chk("data_out", 32'(data_out), 32'(m_job.corr[14:10]));
                    chk("syndrome", 32'(syndrome), 32'(m_job.syn));
                    chk("flags", 32'({error_detected, error_corrected}),
                        32'({m_job.det, m_job.cor}));
                    chk("trial_count", 32'(trial_count), 32'(m_job.k));
                end
                if (flush) begin
                    m_st = 0;
                end else begin
                    case (m_st)
                        0: if (in_valid) begin
                            m_job = ref_job(codeword_in);
                            m_rem = 1 + m_job.k;
                            m_st  = 1;
                        end
                        1: begin
                            m_rem--;
                            if (m_rem == 0) m_st = 2;
                        end
                        default: if (out_ready) m_st = 0;
                    endcase
                end
            end
        end
    end

    task automatic timeout(input string name);
        $display("FAIL timeout_%s actual=expired required=event t=%0t", name, $time);
        tmo_count++;
    endtask

    task automatic send(input logic [14:0] w);
        bit done;
        done = 1'b0;
        in_valid    = 1'b1;
        codeword_in = w;
        for (int n = 0; n < 300 && !done; n++) begin
            done = in_ready;
            @(posedge clk); #1;
        end
        if (!done) timeout("accept");
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = in_ready;
        for (int n = 0; n < 300 && !done; n++) begin
            @(posedge clk); #1;
            done = in_ready;
        end
        if (!done) timeout("idle");
    endtask

    task automatic wait_trials(input logic [6:0] n_target);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(posedge clk); #1;
            done = (trial_count == n_target);
        end
        if (!done) timeout("trials");
    endtask

    task automatic wait_out_valid();
        bit done;
        done = out_valid;
        for (int n = 0; n < 300 && !done; n++) begin
            @(posedge clk); #1;
            done = out_valid;
        end
        if (!done) timeout("out_valid");
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        codeword_in = 15'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(15'h0537);
        wait_idle();
        send(15'h0536);
        wait_idle();
        send(15'h4537);
        wait_idle();
        send(15'h0534);
        wait_idle();
        send(15'h0530);
        wait_idle();

        // Backpressure while a second word is offered.
        out_ready = 1'b0;
        send(15'h0536);
        wait_out_valid();
        in_valid    = 1'b1;
        codeword_in = 15'h0534;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(15'h0534);
        wait_idle();

        send(15'h0530);
        wait_trials(7'd50);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        send(15'h0536);
        wait_idle();

        send(15'h0530);
        wait_trials(7'd50);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(15'h4537);
        wait_idle();

        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            in_valid    = ($urandom_range(0, 1) == 1);
            codeword_in = gen_word();
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 299) == 0);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bch_decode_sequencer.md
BCH_DECODE_SEQUENCER -- requirements
Module: bch_decode_sequencer

Interface
REQ-001 SHALL have parameter MAX_ERR, default 2, meaning the maximum error weight searched (legal values 1 or 2).
REQ-002 SHALL have parameter GEN, default 11'b10100110111, meaning the (15,5) BCH generator polynomial, MSB = x^10.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, meaning a synchronous abort of the current job.
REQ-006 SHALL have port in_valid, input, 1, meaning codeword_in is valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the block can accept a codeword.
REQ-008 SHALL have port codeword_in, input, 15, meaning the received codeword {data[4:0], parity[9:0]}.
REQ-009 SHALL have port out_valid, output, 1, meaning the result outputs are valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-011 SHALL have port data_out, output, 5, meaning corrected_codeword[14:10].
REQ-012 SHALL have port corrected_codeword, output, 15, meaning the corrected codeword, or the received codeword if not corrected.
REQ-013 SHALL have port syndrome, output, 10, meaning the remainder of the received codeword modulo GEN.
REQ-014 SHALL have ports error_detected and error_corrected, outputs, 1 each, meaning syndrome nonzero and correction found, respectively.
REQ-015 SHALL have port trial_count, output, 7, meaning the number of trial patterns tested for this job.
REQ-016 SHALL have port busy, output, 1, meaning the state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, SYND, SCAN1, SCAN2 and DONE, with in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-018 IDLE: in_valid&&in_ready SHALL register codeword_in, clear trial_count, clear the error flags and move to SYND.
REQ-019 SYND (one cycle): SHALL register the syndrome of the captured word; if the syndrome is zero, go to DONE (error_detected=0); otherwise set error_detected=1 and go to SCAN1 with i=0.
REQ-020 SCAN1: each cycle SHALL test exactly one pattern (captured word with bit i flipped) and increment trial_count.
REQ-021 SCAN1: a zero remainder SHALL cause a move to DONE with corrected_codeword=trial and error_corrected=1.
REQ-022 SCAN1: a failure at i=14 SHALL cause a move to SCAN2 (i=0, j=1) if MAX_ERR=2, else to DONE uncorrected.
REQ-023 SCAN2: SHALL test one pair per cycle, flipping bits i and j, in order i ascending then j ascending (i<j), incrementing trial_count; on a hit, go to DONE corrected.
REQ-024 SCAN2: a failure at (13,14) SHALL cause a move to DONE with error_corrected=0 and corrected_codeword equal to the received word.
REQ-025 Latency: out_valid SHALL rise on edge (1+k) after the accept edge, where k=trial_count (k=0 for a clean word; 120 maximum).
REQ-026 DONE: all outputs SHALL hold stable until out_valid&&out_ready, then move to IDLE on that edge; no accept is possible in the same cycle.
REQ-027 in_valid asserted while busy SHALL be ignored, and codeword_in SHALL NOT be sampled.
REQ-028 flush SHALL force IDLE on the next edge from any state, has priority over all other inputs, and drops any pending result (out_valid=0).
REQ-029 The syndrome function SHALL be modulo-2 long division of the 15-bit word by GEN (bits 14..10 eliminated), returning bits [9:0].

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE and clear every output to 0 except in_ready, which SHALL be 1; reset mid-scan SHALL abandon the job.
REQ-031 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-032 Accept 15'h0537 -> out_valid after 1 edge, syndrome=0, error_detected=0, error_corrected=0, data_out=5'b00001, trial_count=0.
REQ-033 Accept 15'h0536 -> out_valid after 2 edges, syndrome=10'h001, corrected_codeword=15'h0537, error_corrected=1, trial_count=1.
REQ-034 Accept 15'h4537 -> trial_count=15, out_valid after 16 edges, corrected_codeword=15'h0537; also 15'h0534 -> trial_count=16, corrected to 15'h0537.
REQ-035 Accept 15'h0530 (3 errors) -> trial_count=120, out_valid after 121 edges, error_detected=1, error_corrected=0, corrected_codeword=15'h0530.
REQ-036 Hold out_ready=0 for 5 cycles in DONE, with in_valid pulsed -> outputs stable, in_ready=0, and the second word is accepted only after out_ready.
REQ-037 Assert flush at trial 50, and separately rst_n low at trial 50 -> IDLE next edge (flush) or immediately (reset), out_valid=0, and the next job completes correctly.
